mc_ctrl_fsm: RTL and testbench

//  Multicycle MIPS main controller. A Moore FSM sequences a shared-ALU/shared-memory datapath through

---
 rtl/mc_ctrl_fsm_pkg.sv | 65 ++++++
 rtl/mc_ctrl_fsm_ctrl_out_dec.sv | 85 ++++++++
 rtl/mc_ctrl_fsm.sv | 107 ++++++++++
 tb/tb_mc_ctrl_fsm.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle MIPS main controller: state encoding,
// opcode/funct values, datapath mux encodings and the internal control word.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FUNCT_SLL = 6'b000000;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_write;
        logic       reg_dst_rtrd;
        logic       mem_to_reg;
        logic       enable_wreg;
        logic       alu_src_a;
        logic       apply_shift;
        logic [1:0] alu_src_b;
        logic [1:0] alu_alt_ctrl;
        logic [1:0] pc_src;
        logic       illegal;
    } ctrl_t;

    // States whose exit back to FETCH completes an instruction.
    function automatic logic state_retires(input state_t s);
        return (s == S_MEMWB)  || (s == S_MEMWR)  || (s == S_ALUWB) ||
               (s == S_BRANCH) || (s == S_ADDIWB) || (s == S_JUMP);
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_ctrl_out_dec.sv
// Combinational lookup from controller state (plus the few gating inputs)
// to the datapath control word.
module ctrl_out_dec
    import mips_pkg::*;
(
    input  state_t     state_i,
    input  logic [5:0] op_i6,
    input  logic [5:0] funct_i6,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    logic is_legal;

    assign is_legal = (op_i6 == OP_LW)   || (op_i6 == OP_SW)  ||
                      (op_i6 == OP_RTYPE) || (op_i6 == OP_BEQ) ||
                      (op_i6 == OP_ADDI)  || (op_i6 == OP_J);

    always_comb begin
        ctrl_o = '0;
        unique case (state_i)
            S_FETCH: begin
                ctrl_o.alu_src_b    = SRCB_FOUR;
                ctrl_o.alu_alt_ctrl = ALU_ADD;
                ctrl_o.pc_src       = PCSRC_ALU;
                ctrl_o.ir_write     = mem_ready_i;
                ctrl_o.pc_write     = mem_ready_i;
            end
            S_DECODE: begin
                // Branch target is precomputed here while the register file reads.
                ctrl_o.alu_src_b    = SRCB_IMMSH2;
                ctrl_o.alu_alt_ctrl = ALU_ADD;
                ctrl_o.illegal      = !is_legal;
            end
            S_MEMADR: begin
                ctrl_o.alu_src_a    = 1'b1;
                ctrl_o.alu_src_b    = SRCB_IMM;
                ctrl_o.alu_alt_ctrl = ALU_ADD;
            end
            S_MEMRD: begin
                ctrl_o.iord = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.mem_to_reg  = 1'b1;
                ctrl_o.enable_wreg = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.iord      = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            S_EXEC: begin
                ctrl_o.alu_src_a    = 1'b1;
                ctrl_o.alu_src_b    = SRCB_RT;
                ctrl_o.alu_alt_ctrl = ALU_FUNCT;
                ctrl_o.apply_shift  = (funct_i6 == FUNCT_SLL);
            end
            S_ALUWB: begin
                ctrl_o.reg_dst_rtrd = 1'b1;
                ctrl_o.enable_wreg  = 1'b1;
                ctrl_o.apply_shift  = (funct_i6 == FUNCT_SLL);
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a    = 1'b1;
                ctrl_o.alu_src_b    = SRCB_RT;
                ctrl_o.alu_alt_ctrl = ALU_SUB;
                ctrl_o.pc_src       = PCSRC_ALUOUT;
                ctrl_o.branch       = 1'b1;
            end
            S_ADDIEX: begin
                ctrl_o.alu_src_a    = 1'b1;
                ctrl_o.alu_src_b    = SRCB_IMM;
                ctrl_o.alu_alt_ctrl = ALU_ADD;
            end
            S_ADDIWB: begin
                ctrl_o.enable_wreg = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_src   = PCSRC_JUMP;
                ctrl_o.pc_write = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main controller: state register, next-state logic and
// retired-instruction counter; control word comes from ctrl_out_dec.
module mc_ctrl_fsm
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic [5:0]       op_i6,
    input  logic [5:0]       funct_i6,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             ir_write_o,
    output logic             pc_en_o,
    output logic             iord_o,
    output logic             mem_write_o,
    output logic             reg_dst_rtrd_o,
    output logic             mem_to_reg_o,
    output logic             enable_wreg_o,
    output logic             alu_src_a_o,
    output logic             apply_shift_o,
    output logic [1:0]       alu_src_b_o2,
    output logic [1:0]       alu_alt_ctrl_o2,
    output logic [1:0]       pc_src_o2,
    output logic             illegal_o,
    output logic [CNT_W-1:0] instr_count_o
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    ctrl_t              ctrl;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:  state_d = mem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE: begin
                unique case (op_i6)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (op_i6 == OP_LW)      state_d = S_MEMRD;
                else if (op_i6 == OP_SW) state_d = S_MEMWR;
                else                     state_d = S_FETCH;
            end
            S_MEMRD:  state_d = mem_ready_i ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ready_i ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Illegal opcodes leave DECODE for FETCH but never retire.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_d == S_FETCH) && state_retires(state_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    ctrl_out_dec u_dec (
        .state_i     (state_q),
        .op_i6       (op_i6),
        .funct_i6    (funct_i6),
        .mem_ready_i (mem_ready_i),
        .ctrl_o      (ctrl)
    );

    assign ir_write_o      = ctrl.ir_write;
    assign pc_en_o         = ctrl.pc_write | (ctrl.branch & zero_i);
    assign iord_o          = ctrl.iord;
    assign mem_write_o     = ctrl.mem_write;
    assign reg_dst_rtrd_o  = ctrl.reg_dst_rtrd;
    assign mem_to_reg_o    = ctrl.mem_to_reg;
    assign enable_wreg_o   = ctrl.enable_wreg;
    assign alu_src_a_o     = ctrl.alu_src_a;
    assign apply_shift_o   = ctrl.apply_shift;
    assign alu_src_b_o2    = ctrl.alu_src_b;
    assign alu_alt_ctrl_o2 = ctrl.alu_alt_ctrl;
    assign pc_src_o2       = ctrl.pc_src;
    assign illegal_o       = ctrl.illegal;
    assign instr_count_o   = cnt_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Randomized bench for mc_ctrl_fsm: each instruction is expanded into a
// cycle-by-cycle expectation list from the instruction-level timing rules.
module tb_mc_ctrl_fsm;

    localparam int unsigned CW = 4;

    logic          clk_i = 1'b0;
    logic          reset_ni = 1'b0;
    logic [5:0]    op_i6 = '0;
    logic [5:0]    funct_i6 = '0;
    logic          zero_i = 1'b0;
    logic          mem_ready_i = 1'b0;
    logic          ir_write_o, pc_en_o, iord_o, mem_write_o, reg_dst_rtrd_o;
    logic          mem_to_reg_o, enable_wreg_o, alu_src_a_o, apply_shift_o, illegal_o;
    logic [1:0]    alu_src_b_o2, alu_alt_ctrl_o2, pc_src_o2;
    logic [CW-1:0] instr_count_o;

    mc_ctrl_fsm #(.CNT_W(CW)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .op_i6(op_i6), .funct_i6(funct_i6),
        .zero_i(zero_i), .mem_ready_i(mem_ready_i), .ir_write_o(ir_write_o),
        .pc_en_o(pc_en_o), .iord_o(iord_o), .mem_write_o(mem_write_o),
        .reg_dst_rtrd_o(reg_dst_rtrd_o), .mem_to_reg_o(mem_to_reg_o),
        .enable_wreg_o(enable_wreg_o), .alu_src_a_o(alu_src_a_o),
        .apply_shift_o(apply_shift_o), .alu_src_b_o2(alu_src_b_o2),
        .alu_alt_ctrl_o2(alu_alt_ctrl_o2), .pc_src_o2(pc_src_o2),
        .illegal_o(illegal_o), .instr_count_o(instr_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic       ir_write, pc_en, iord, mem_write, reg_dst, mem_to_reg, wreg, srca, shift;
        logic [1:0] srcb, alu, pcsrc;
        logic       illegal;
    } cw_t;

    typedef struct {
        logic rdy;
        logic z;
        cw_t  cw;
    } step_t;

    int unsigned n_chk = 0;
    int unsigned n_bad = 0;
    int unsigned exp_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic cw_t observe();
        cw_t c;
        c.ir_write = ir_write_o;    c.pc_en = pc_en_o;         c.iord = iord_o;
        c.mem_write = mem_write_o;  c.reg_dst = reg_dst_rtrd_o; c.mem_to_reg = mem_to_reg_o;
        c.wreg = enable_wreg_o;     c.srca = alu_src_a_o;      c.shift = apply_shift_o;
        c.srcb = alu_src_b_o2;      c.alu = alu_alt_ctrl_o2;   c.pcsrc = pc_src_o2;
        c.illegal = illegal_o;
        return c;
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(1, 0));
    endfunction

    function automatic cw_t fetch_word(input logic done);
        cw_t c = '0;
        c.srcb = 2'b01;
        c.ir_write = done;
        c.pc_en = done;
        return c;
    endfunction

    // One instruction from fetch to retirement. abort_at >= 0 pulls reset
    // asynchronously right after that step has been checked.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] funct, input logic z,
                             input int unsigned wf, input int unsigned wd,
                             input int abort_at, input string name);
        step_t q[$];
        cw_t   c;
        logic  legal;
        legal = (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
                (op == 6'b000100) || (op == 6'b001000) || (op == 6'b000010);

        for (int unsigned i = 0; i < wf; i++) q.push_back('{rdy: 1'b0, z: rnd(), cw: fetch_word(1'b0)});
        q.push_back('{rdy: 1'b1, z: rnd(), cw: fetch_word(1'b1)});
        c = '0; c.srcb = 2'b11; c.illegal = !legal;
        q.push_back('{rdy: rnd(), z: rnd(), cw: c});

        case (op)
            6'b100011, 6'b101011: begin
                c = '0; c.srca = 1'b1; c.srcb = 2'b10;
                q.push_back('{rdy: rnd(), z: rnd(), cw: c});
                c = '0; c.iord = 1'b1; c.mem_write = (op == 6'b101011);
                for (int unsigned i = 0; i < wd; i++) q.push_back('{rdy: 1'b0, z: rnd(), cw: c});
                q.push_back('{rdy: 1'b1, z: rnd(), cw: c});
                if (op == 6'b100011) begin
                    c = '0; c.mem_to_reg = 1'b1; c.wreg = 1'b1;
                    q.push_back('{rdy: rnd(), z: rnd(), cw: c});
                end
            end
            6'b000000: begin
                c = '0; c.srca = 1'b1; c.alu = 2'b10; c.shift = (funct == 6'b000000);
                q.push_back('{rdy: rnd(), z: rnd(), cw: c});
                c = '0; c.reg_dst = 1'b1; c.wreg = 1'b1; c.shift = (funct == 6'b000000);
                q.push_back('{rdy: rnd(), z: rnd(), cw: c});
            end
            6'b000100: begin
                c = '0; c.srca = 1'b1; c.alu = 2'b01; c.pcsrc = 2'b01; c.pc_en = z;
                q.push_back('{rdy: rnd(), z: z, cw: c});
            end
            6'b001000: begin
                c = '0; c.srca = 1'b1; c.srcb = 2'b10;
                q.push_back('{rdy: rnd(), z: rnd(), cw: c});
                c = '0; c.wreg = 1'b1;
                q.push_back('{rdy: rnd(), z: rnd(), cw: c});
            end
            6'b000010: begin
                c = '0; c.pcsrc = 2'b10; c.pc_en = 1'b1;
                q.push_back('{rdy: rnd(), z: rnd(), cw: c});
            end
            default: ;
        endcase

        foreach (q[i]) begin
            @(negedge clk_i);
            if (i == 0) begin
                op_i6 = op;
                funct_i6 = funct;
            end
            mem_ready_i = q[i].rdy;
            zero_i = q[i].z;
            #1;
            if (i == 0) chk($sformatf("%s.count", name), 32'(instr_count_o), exp_cnt);
            chk($sformatf("%s.c%0d", name, i), 32'(observe()), 32'(q[i].cw));
            if (i == abort_at) begin
                mem_ready_i = 1'b0;
                reset_ni = 1'b0;
                #1;
                chk($sformatf("%s.rst_memwr", name), 32'(mem_write_o), 32'd0);
                chk($sformatf("%s.rst_count", name), 32'(instr_count_o), 32'd0);
                chk($sformatf("%s.rst_state", name), 32'(observe()), 32'(fetch_word(1'b0)));
                exp_cnt = 0;
                @(negedge clk_i);
                reset_ni = 1'b1;
                return;
            end
        end
        if (legal) exp_cnt = (exp_cnt + 1) % (1 << CW);
    endtask

    function automatic logic [5:0] rand_illegal();
        logic [5:0] op;
        do op = 6'($urandom);
        while (op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010});
        return op;
    endfunction

    initial begin
        logic [5:0] ops [6];
        logic [5:0] op, funct;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};

        #12;
        chk("reset.count", 32'(instr_count_o), 32'd0);
        chk("reset.illegal", 32'(illegal_o), 32'd0);
        chk("reset.state", 32'(observe()), 32'(fetch_word(1'b0)));
        @(negedge clk_i);
        reset_ni = 1'b1;

        run_instr(6'b100011, 6'h15, 1'b0, 0, 0, -1, "lw");
        run_instr(6'b001000, 6'h00, 1'b0, 3, 0, -1, "addi_fwait");
        run_instr(6'b000100, 6'h00, 1'b1, 0, 0, -1, "beq_taken");
        run_instr(6'b000100, 6'h00, 1'b0, 0, 0, -1, "beq_not");
        run_instr(6'b000000, 6'b000000, 1'b0, 0, 0, -1, "sll");
        run_instr(6'b000000, 6'b100000, 1'b0, 0, 0, -1, "add");
        run_instr(6'b111111, 6'h00, 1'b0, 0, 0, -1, "illegal");
        run_instr(6'b101011, 6'h00, 1'b0, 1, 2, -1, "sw");

        while (exp_cnt != (1 << CW) - 1) run_instr(6'b000010, 6'h00, 1'b0, 0, 0, -1, "j_fill");
        run_instr(6'b000010, 6'h00, 1'b0, 0, 0, -1, "j_wrap");
        @(negedge clk_i);
        mem_ready_i = 1'b0;
        #1;
        chk("wrap.count", 32'(instr_count_o), 32'd0);

        run_instr(6'b101011, 6'h00, 1'b0, 0, 3, 4, "sw_reset");

        for (int k = 0; k < 250; k++) begin
            if ($urandom_range(7, 0) == 0) op = rand_illegal();
            else op = ops[$urandom_range(5, 0)];
            funct = rnd() ? 6'b000000 : 6'($urandom);
            run_instr(op, funct, rnd(), $urandom_range(3, 0), $urandom_range(3, 0), -1,
                      $sformatf("rnd%0d_op%02h", k, op));
        end
        @(negedge clk_i);
        mem_ready_i = 1'b0;
        #1;
        chk("final.count", 32'(instr_count_o), exp_cnt);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
